multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Next-generation main controller for the multicycle MIPS core: Moore FSM plus ALU decode driving the datapath muxes/enables.
//  Adds LW/SW, BNE, SUB/AND/OR/SLT, ANDI/SLTI, memory wait-state handshake and illegal-instruction trap.
//  Sits between instruction register (opcode/funct) and datapath; PC enable = pc_write | (branch & (zero ^ branch_ne)) in datapath.
// PARAMETERS
//  ALU_CTRL_W  3  width of alu_control; codes zero-extended if >3
//  MEM_WAIT    1  1: honour mem_ready; 0: mem_ready treated as constant 1
//  TRAP_EN     1  1: unknown opcode/funct -> TRAP; 0: treated as NOP (DECODE -> FETCH)
// PORTS
//  clk          in   1  core clock, all state on rising edge
//  rst_n        in   1  synchronous, active-low reset
//  opcode       in   6  instr[31:26] from IR
//  funct        in   6  instr[5:0] from IR
//  mem_ready    in   1  memory completes access this cycle
//  mem_req      out  1  memory access requested (FETCH, MEMRD, MEMWR)
//  pc_write     out  1  unconditional PC update
//  branch       out  1  conditional PC update (BEQ/BNE)
//  branch_ne    out  1  invert zero for BNE
//  iord         out  1  0: PC addresses memory, 1: ALUOut
//  mem_write    out  1  memory write strobe
//  ir_write     out  1  latch IR
//  reg_write    out  1  register file write
//  reg_dst      out  1  0: rt, 1: rd
//  mem_to_reg   out  1  0: ALUOut, 1: MDR
//  alu_src_a    out  1  0: PC, 1: A
//  alu_src_b    out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
//  alu_control  out  ALU_CTRL_W  010 add,110 sub,000 and,001 or,111 slt
//  pc_src       out  2  00 ALU, 01 ALUOut, 10 jump target
//  zero_ext     out  1  zero-extend immediate (ANDI/ORI)
//  illegal_op   out  1  one-cycle pulse in TRAP
//  state_o      out  4  current state, debug
// BEHAVIOUR
//  Reset: rst_n=0 at edge -> state=FETCH; while rst_n=0 all outputs forced 0 (no PC/IR/RF/mem writes).
//  Outputs combinational from state (+opcode/funct for alu_control in EX); next state registered.
//  States: FETCH,DECODE,MEMADR,MEMRD,MEMWB,MEMWR,RTYPE_EX,ALU_WB,IMM_EX,IMM_WB,BRANCH,JUMP,TRAP.
//  FETCH: mem_req,iord=0,src_a=0,src_b=01,add,pc_src=00; ir_write/pc_write only when mem_ready; stay until mem_ready.
//  DECODE: src_a=0,src_b=11,add (branch target). LW/SW(23/2B)->MEMADR; R(00)->RTYPE_EX; BEQ/BNE(04/05)->BRANCH;
//   J(02)->JUMP; ADDI/ANDI/ORI/SLTI(08/0C/0D/0A)->IMM_EX; else TRAP (TRAP_EN=1) or FETCH.
//  MEMADR: src_a=1,src_b=10,add; LW->MEMRD, SW->MEMWR.
//  MEMRD: mem_req,iord=1; stay until mem_ready -> MEMWB. MEMWB: reg_write,mem_to_reg=1,reg_dst=0 -> FETCH.
//  MEMWR: mem_req,iord=1,mem_write held until mem_ready -> FETCH (exactly one accepted write).
//  RTYPE_EX: src_a=1,src_b=00, funct 20/22/24/25/2A -> add/sub/and/or/slt; unknown funct -> TRAP/FETCH. -> ALU_WB.
//  ALU_WB: reg_write,reg_dst=1,mem_to_reg=0 -> FETCH.  IMM_EX: src_a=1,src_b=10, ADDI add,ANDI and,ORI or,SLTI slt;
//   zero_ext=1 for ANDI/ORI in IMM_EX and IMM_WB; -> IMM_WB: reg_write,reg_dst=0 -> FETCH.
//  BRANCH: src_a=1,src_b=00,sub,branch=1,pc_src=01,branch_ne=(opcode==05) -> FETCH.  JUMP: pc_write,pc_src=10 -> FETCH.
//  TRAP: illegal_op=1 one cycle, no writes -> FETCH.
//  Latency (mem_ready=1): BEQ/BNE/J 3, R/imm 4, SW 4, LW 5 cycles; each wait cycle adds one.
//  mem_ready ignored outside FETCH/MEMRD/MEMWR. Opcode/funct sampled only per state; IR stable after FETCH.
//  Reset mid-wait: access abandoned, mem_req drops with outputs; restart at FETCH.
//  Unreachable encodings -> FETCH, all outputs 0.
// STRUCTURE
//  Package mc_pkg: opcode/funct constants, state encoding, ALU control codes, alu_src_b/pc_src codes.
//  Sub-module alu_decoder: (opcode, funct, alu_op) -> alu_control, funct_valid; controller = FSM + output decode.
// TESTING
//  Reset held 3 cycles mid-MEMRD -> all outputs 0, state_o=FETCH after release, mem_req=1 first cycle.
//  ADD (op 00, funct 20), mem_ready=1 -> FETCH,DECODE,RTYPE_EX(ctrl 010),ALU_WB(reg_write,reg_dst=1): 4 cycles.
//  LW with mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, then MEMWB mem_to_reg=1; total 7 cycles.
//  SW, mem_ready low 1 cycle in MEMWR -> mem_write high 2 cycles, one accept, then FETCH.
//  BNE (05) -> BRANCH with branch=1,branch_ne=1,ctrl=110,pc_src=01; BEQ gives branch_ne=0.
//  Opcode 3F / R funct 3F, TRAP_EN=1 -> illegal_op pulse 1 cycle, no writes; TRAP_EN=0 -> back to FETCH, no pulse.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle MIPS main controller.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU3_W  = 3;

  localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD    = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR    = 4'd5;
  localparam logic [STATE_W-1:0] S_RTYPE_EX = 4'd6;
  localparam logic [STATE_W-1:0] S_ALU_WB   = 4'd7;
  localparam logic [STATE_W-1:0] S_IMM_EX   = 4'd8;
  localparam logic [STATE_W-1:0] S_IMM_WB   = 4'd9;
  localparam logic [STATE_W-1:0] S_BRANCH   = 4'd10;
  localparam logic [STATE_W-1:0] S_JUMP     = 4'd11;
  localparam logic [STATE_W-1:0] S_TRAP     = 4'd12;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] F_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] F_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'h2A;

  localparam logic [ALU3_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU3_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU3_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU3_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU3_W-1:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_IMM   = 2'd3
  } alu_op_e;

  // Datapath control word; alu_control is kept separate because its width is parameterised.
  typedef struct packed {
    logic       mem_req;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       zero_ext;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_zero_ext_op(input logic [OP_W-1:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-register / datapath side bundle of the multicycle controller.
interface multicycle_controller_if #(
  parameter int unsigned ALU_CTRL_W = 3
);
  import mc_pkg::*;

  logic [OP_W-1:0]       opcode;
  logic [FUNCT_W-1:0]    funct;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  pc_write;
  logic                  branch;
  logic                  branch_ne;
  logic                  iord;
  logic                  mem_write;
  logic                  ir_write;
  logic                  reg_write;
  logic                  reg_dst;
  logic                  mem_to_reg;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [1:0]            pc_src;
  logic                  zero_ext;
  logic                  illegal_op;
  logic [STATE_W-1:0]    state_o;

  modport slave (
    input  opcode, funct, mem_ready,
    output mem_req, pc_write, branch, branch_ne, iord, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control,
           pc_src, zero_ext, illegal_op, state_o
  );

  modport master (
    output opcode, funct, mem_ready,
    input  mem_req, pc_write, branch, branch_ne, iord, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control,
           pc_src, zero_ext, illegal_op, state_o
  );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode from the FSM's alu_op plus opcode/funct; flags unknown R-type functs.
module alu_decoder
  import mc_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic [OP_W-1:0]       opcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  alu_op_e               alu_op,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  funct_valid
);

  logic [ALU3_W-1:0] code;

  always_comb begin
    code        = ALU_ADD;
    funct_valid = 1'b0;
    case (alu_op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        funct_valid = 1'b1;
        case (funct)
          F_ADD:   code = ALU_ADD;
          F_SUB:   code = ALU_SUB;
          F_AND:   code = ALU_AND;
          F_OR:    code = ALU_OR;
          F_SLT:   code = ALU_SLT;
          default: funct_valid = 1'b0;
        endcase
      end
      ALUOP_IMM: begin
        case (opcode)
          OP_ANDI: code = ALU_AND;
          OP_ORI:  code = ALU_OR;
          OP_SLTI: code = ALU_SLT;
          default: code = ALU_ADD;
        endcase
      end
    endcase
  end

  // Wider ALU control buses get the 3-bit code zero-extended.
  assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main controller: Moore FSM driving datapath muxes/enables, with
// memory wait-state handshake and illegal-instruction trap.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter bit          MEM_WAIT   = 1'b1,
  parameter bit          TRAP_EN    = 1'b1
) (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_controller_if.slave  bus
);

  // Where an unrecognised opcode/funct goes: trap state, or silently back to fetch.
  localparam logic [STATE_W-1:0] S_BAD = TRAP_EN ? S_TRAP : S_FETCH;

  logic [STATE_W-1:0]    state;
  logic [STATE_W-1:0]    state_nx;
  ctrl_t                 ctrl;
  alu_op_e               alu_op;
  logic                  alu_en;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  funct_valid;
  logic                  mem_rdy;

  assign mem_rdy = MEM_WAIT ? bus.mem_ready : 1'b1;

  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .opcode      (bus.opcode),
    .funct       (bus.funct),
    .alu_op      (alu_op),
    .alu_control (alu_ctrl),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_nx = S_FETCH;
    ctrl     = '0;
    alu_op   = ALUOP_ADD;
    alu_en   = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_src    = PCSRC_ALU;
        alu_en         = 1'b1;
        if (mem_rdy) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_nx      = S_DECODE;
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        alu_en         = 1'b1;
        case (bus.opcode)
          OP_LW, OP_SW:                        state_nx = S_MEMADR;
          OP_RTYPE:                            state_nx = S_RTYPE_EX;
          OP_BEQ, OP_BNE:                      state_nx = S_BRANCH;
          OP_J:                                state_nx = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_nx = S_IMM_EX;
          default:                             state_nx = S_BAD;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        alu_en         = 1'b1;
        if (bus.opcode == OP_SW)      state_nx = S_MEMWR;
        else if (bus.opcode == OP_LW) state_nx = S_MEMRD;
        else                          state_nx = S_FETCH;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        state_nx     = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        state_nx       = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        alu_op         = ALUOP_FUNCT;
        alu_en         = 1'b1;
        state_nx       = funct_valid ? S_ALU_WB : S_BAD;
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_IMM_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.zero_ext  = is_zero_ext_op(bus.opcode);
        alu_op         = ALUOP_IMM;
        alu_en         = 1'b1;
        state_nx       = S_IMM_WB;
      end
      S_IMM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.zero_ext  = is_zero_ext_op(bus.opcode);
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = (bus.opcode == OP_BNE);
        ctrl.pc_src    = PCSRC_ALUOUT;
        alu_op         = ALUOP_SUB;
        alu_en         = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      S_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
      default: state_nx = S_FETCH;
    endcase
    // Reset suppresses every strobe immediately, including an in-flight memory access.
    if (!rst_n) begin
      ctrl   = '0;
      alu_en = 1'b0;
    end
  end

  assign bus.mem_req     = ctrl.mem_req;
  assign bus.pc_write    = ctrl.pc_write;
  assign bus.branch      = ctrl.branch;
  assign bus.branch_ne   = ctrl.branch_ne;
  assign bus.iord        = ctrl.iord;
  assign bus.mem_write   = ctrl.mem_write;
  assign bus.ir_write    = ctrl.ir_write;
  assign bus.reg_write   = ctrl.reg_write;
  assign bus.reg_dst     = ctrl.reg_dst;
  assign bus.mem_to_reg  = ctrl.mem_to_reg;
  assign bus.alu_src_a   = ctrl.alu_src_a;
  assign bus.alu_src_b   = ctrl.alu_src_b;
  assign bus.pc_src      = ctrl.pc_src;
  assign bus.zero_ext    = ctrl.zero_ext;
  assign bus.illegal_op  = ctrl.illegal_op;
  assign bus.alu_control = alu_en ? alu_ctrl : '0;
  assign bus.state_o     = rst_n ? state : S_FETCH;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instruction sequences, per-cycle expectations.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst_n2;
  logic [5:0] op, fn;
  logic       rdy;

  multicycle_controller_if #(.ALU_CTRL_W(3)) bus  ();
  multicycle_controller_if #(.ALU_CTRL_W(3)) bus2 ();

  assign bus.opcode     = op;
  assign bus.funct      = fn;
  assign bus.mem_ready  = rdy;
  assign bus2.opcode    = op;
  assign bus2.funct     = fn;
  assign bus2.mem_ready = rdy;

  multicycle_controller #(.ALU_CTRL_W(3), .MEM_WAIT(1'b1), .TRAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  multicycle_controller #(.ALU_CTRL_W(3), .MEM_WAIT(1'b1), .TRAP_EN(1'b0)) dut_nt (
    .clk(clk), .rst_n(rst_n2), .bus(bus2)
  );

  ctrl_t act1, act2;
  assign act1 = {bus.mem_req, bus.pc_write, bus.branch, bus.branch_ne, bus.iord, bus.mem_write,
                 bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                 bus.alu_src_b, bus.pc_src, bus.zero_ext, bus.illegal_op};
  assign act2 = {bus2.mem_req, bus2.pc_write, bus2.branch, bus2.branch_ne, bus2.iord, bus2.mem_write,
                 bus2.ir_write, bus2.reg_write, bus2.reg_dst, bus2.mem_to_reg, bus2.alu_src_a,
                 bus2.alu_src_b, bus2.pc_src, bus2.zero_ext, bus2.illegal_op};

  // Hand-written expected control words per state/situation.
  localparam ctrl_t Z      = '0;
  localparam ctrl_t E_FET  = '{mem_req:1'b1, pc_write:1'b1, ir_write:1'b1, alu_src_b:2'b01, default:'0};
  localparam ctrl_t E_FWT  = '{mem_req:1'b1, alu_src_b:2'b01, default:'0};
  localparam ctrl_t E_DEC  = '{alu_src_b:2'b11, default:'0};
  localparam ctrl_t E_MADR = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam ctrl_t E_MRD  = '{mem_req:1'b1, iord:1'b1, default:'0};
  localparam ctrl_t E_MWB  = '{reg_write:1'b1, mem_to_reg:1'b1, default:'0};
  localparam ctrl_t E_MWR  = '{mem_req:1'b1, iord:1'b1, mem_write:1'b1, default:'0};
  localparam ctrl_t E_REX  = '{alu_src_a:1'b1, default:'0};
  localparam ctrl_t E_AWB  = '{reg_write:1'b1, reg_dst:1'b1, default:'0};
  localparam ctrl_t E_IEX  = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam ctrl_t E_IEXZ = '{alu_src_a:1'b1, alu_src_b:2'b10, zero_ext:1'b1, default:'0};
  localparam ctrl_t E_IWB  = '{reg_write:1'b1, default:'0};
  localparam ctrl_t E_IWBZ = '{reg_write:1'b1, zero_ext:1'b1, default:'0};
  localparam ctrl_t E_BEQ  = '{alu_src_a:1'b1, branch:1'b1, pc_src:2'b01, default:'0};
  localparam ctrl_t E_BNE  = '{alu_src_a:1'b1, branch:1'b1, branch_ne:1'b1, pc_src:2'b01, default:'0};
  localparam ctrl_t E_JMP  = '{pc_write:1'b1, pc_src:2'b10, default:'0};
  localparam ctrl_t E_TRAP = '{illegal_op:1'b1, default:'0};

  typedef struct {
    string      name;
    bit         sel;
    logic [3:0] st;
    ctrl_t      c;
    int         alu;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests  = 0;
  int   failed = 0;

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      logic [3:0] a_st;
      ctrl_t      a_c;
      logic [2:0] a_alu;
      e     = q.pop_front();
      a_st  = e.sel ? bus2.state_o : bus.state_o;
      a_c   = e.sel ? act2 : act1;
      a_alu = e.sel ? bus2.alu_control : bus.alu_control;
      tests++;
      if (a_st !== e.st) begin
        failed++;
        $display("FAIL %s state: got %0d expected %0d", e.name, a_st, e.st);
      end
      tests++;
      if (a_c !== e.c) begin
        failed++;
        $display("FAIL %s ctrl: got %h expected %h", e.name, a_c, e.c);
      end
      if (e.alu >= 0) begin
        tests++;
        if (a_alu !== 3'(e.alu)) begin
          failed++;
          $display("FAIL %s alu_control: got %b expected %b", e.name, a_alu, 3'(e.alu));
        end
      end
    end
  end

  task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic r, input logic rs1,
                     input logic rs2, input bit sel, input string nm, input logic [3:0] st,
                     input ctrl_t c, input int alu);
    exp_t x;
    @(posedge clk);
    #1;
    op = o; fn = f; rdy = r; rst_n = rs1; rst_n2 = rs2;
    x.name = nm; x.sel = sel; x.st = st; x.c = c; x.alu = alu;
    q.push_back(x);
  endtask

  task automatic c1(input logic [5:0] o, input logic [5:0] f, input logic r, input string nm,
                    input logic [3:0] st, input ctrl_t c, input int alu);
    cyc(o, f, r, 1'b1, 1'b0, 1'b0, nm, st, c, alu);
  endtask

  task automatic rtype(input logic [5:0] f, input int alu, input string nm);
    c1(OP_RTYPE, f, 1'b1, {nm, "_f"}, S_FETCH, E_FET, 2);
    c1(OP_RTYPE, f, 1'b0, {nm, "_d"}, S_DECODE, E_DEC, 2);
    c1(OP_RTYPE, f, 1'b0, {nm, "_ex"}, S_RTYPE_EX, E_REX, alu);
    c1(OP_RTYPE, f, 1'b0, {nm, "_wb"}, S_ALU_WB, E_AWB, -1);
  endtask

  task automatic imm(input logic [5:0] o, input ctrl_t ex, input ctrl_t wb, input int alu,
                     input string nm);
    c1(o, 6'h00, 1'b1, {nm, "_f"}, S_FETCH, E_FET, 2);
    c1(o, 6'h00, 1'b1, {nm, "_d"}, S_DECODE, E_DEC, 2);
    c1(o, 6'h00, 1'b1, {nm, "_ex"}, S_IMM_EX, ex, alu);
    c1(o, 6'h00, 1'b0, {nm, "_wb"}, S_IMM_WB, wb, -1);
  endtask

  initial begin
    rst_n = 1'b0; rst_n2 = 1'b0; op = '0; fn = '0; rdy = 1'b0;

    cyc(6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, "rst_a", S_FETCH, Z, 0);
    cyc(6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, "rst_b", S_FETCH, Z, 0);

    rtype(F_ADD, 2, "add");
    c1(OP_RTYPE, F_SUB, 1'b0, "sub_fw", S_FETCH, E_FWT, 2);
    rtype(F_SUB, 6, "sub");
    rtype(F_AND, 0, "and");
    rtype(F_OR,  1, "or");
    rtype(F_SLT, 7, "slt");

    // LW with two wait cycles in MEMRD: seven cycles total.
    c1(OP_LW, 6'h00, 1'b1, "lw_f",   S_FETCH,  E_FET,  2);
    c1(OP_LW, 6'h00, 1'b1, "lw_d",   S_DECODE, E_DEC,  2);
    c1(OP_LW, 6'h00, 1'b1, "lw_adr", S_MEMADR, E_MADR, 2);
    c1(OP_LW, 6'h00, 1'b0, "lw_rd0", S_MEMRD,  E_MRD,  -1);
    c1(OP_LW, 6'h00, 1'b0, "lw_rd1", S_MEMRD,  E_MRD,  -1);
    c1(OP_LW, 6'h00, 1'b1, "lw_rd2", S_MEMRD,  E_MRD,  -1);
    c1(OP_LW, 6'h00, 1'b0, "lw_wb",  S_MEMWB,  E_MWB,  -1);

    // SW with one wait cycle: mem_write high two cycles.
    c1(OP_SW, 6'h00, 1'b1, "sw_f",   S_FETCH,  E_FET,  2);
    c1(OP_SW, 6'h00, 1'b0, "sw_d",   S_DECODE, E_DEC,  2);
    c1(OP_SW, 6'h00, 1'b0, "sw_adr", S_MEMADR, E_MADR, 2);
    c1(OP_SW, 6'h00, 1'b0, "sw_wr0", S_MEMWR,  E_MWR,  -1);
    c1(OP_SW, 6'h00, 1'b1, "sw_wr1", S_MEMWR,  E_MWR,  -1);

    c1(OP_BNE, 6'h00, 1'b1, "bne_f", S_FETCH,  E_FET, 2);
    c1(OP_BNE, 6'h00, 1'b0, "bne_d", S_DECODE, E_DEC, 2);
    c1(OP_BNE, 6'h00, 1'b0, "bne_b", S_BRANCH, E_BNE, 6);
    c1(OP_BEQ, 6'h00, 1'b1, "beq_f", S_FETCH,  E_FET, 2);
    c1(OP_BEQ, 6'h00, 1'b0, "beq_d", S_DECODE, E_DEC, 2);
    c1(OP_BEQ, 6'h00, 1'b0, "beq_b", S_BRANCH, E_BEQ, 6);
    c1(OP_J,   6'h00, 1'b1, "j_f",   S_FETCH,  E_FET, 2);
    c1(OP_J,   6'h00, 1'b0, "j_d",   S_DECODE, E_DEC, 2);
    c1(OP_J,   6'h00, 1'b0, "j_j",   S_JUMP,   E_JMP, -1);

    imm(OP_ADDI, E_IEX,  E_IWB,  2, "addi");
    imm(OP_ANDI, E_IEXZ, E_IWBZ, 0, "andi");
    imm(OP_ORI,  E_IEXZ, E_IWBZ, 1, "ori");
    imm(OP_SLTI, E_IEX,  E_IWB,  7, "slti");

    // Illegal opcode and illegal funct both trap for one cycle.
    c1(6'h3F, 6'h00, 1'b1, "ill_f",  S_FETCH,  E_FET,  2);
    c1(6'h3F, 6'h00, 1'b0, "ill_d",  S_DECODE, E_DEC,  2);
    c1(6'h3F, 6'h00, 1'b0, "ill_t",  S_TRAP,   E_TRAP, -1);
    c1(OP_RTYPE, 6'h3F, 1'b1, "ilf_f",  S_FETCH,    E_FET,  2);
    c1(OP_RTYPE, 6'h3F, 1'b0, "ilf_d",  S_DECODE,   E_DEC,  2);
    c1(OP_RTYPE, 6'h3F, 1'b0, "ilf_ex", S_RTYPE_EX, E_REX,  -1);
    c1(OP_RTYPE, 6'h3F, 1'b0, "ilf_t",  S_TRAP,     E_TRAP, -1);

    // Reset held three cycles while waiting in MEMRD.
    c1(OP_LW, 6'h00, 1'b1, "rlw_f",   S_FETCH,  E_FET,  2);
    c1(OP_LW, 6'h00, 1'b0, "rlw_d",   S_DECODE, E_DEC,  2);
    c1(OP_LW, 6'h00, 1'b0, "rlw_adr", S_MEMADR, E_MADR, 2);
    c1(OP_LW, 6'h00, 1'b0, "rlw_rd",  S_MEMRD,  E_MRD,  -1);
    cyc(OP_LW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rlw_r0", S_FETCH, Z, 0);
    cyc(OP_LW, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, "rlw_r1", S_FETCH, Z, 0);
    cyc(OP_LW, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rlw_r2", S_FETCH, Z, 0);
    c1(OP_RTYPE, F_ADD, 1'b0, "post_fw", S_FETCH, E_FWT, 2);
    rtype(F_ADD, 2, "post_add");

    // Second instance without trap: illegal encodings return straight to FETCH.
    cyc(6'h3F, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, "nt_f",   S_FETCH,    E_FET, 2);
    cyc(6'h3F, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, "nt_d",   S_DECODE,   E_DEC, 2);
    cyc(OP_RTYPE, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b1, "nt_f2",  S_FETCH,    E_FET, 2);
    cyc(OP_RTYPE, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1, "nt_d2",  S_DECODE,   E_DEC, 2);
    cyc(OP_RTYPE, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1, "nt_ex",  S_RTYPE_EX, E_REX, -1);
    cyc(OP_RTYPE, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1, "nt_f3",  S_FETCH,    E_FWT, 2);

    repeat (3) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
